// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state
// encodings and framing constants used by imem_loader and byte_packer.
package loader_pkg;

    // Fixed 3-bit state encodings; CSUM is only reached when
    // IMEM_LOADER_CHECKSUM_EN is defined.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;
    localparam logic [2:0] S_CSUM   = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        LEN_HI = S_LEN_HI,
        LEN_LO = S_LEN_LO,
        DATA   = S_DATA,
        WRITE  = S_WRITE,
        FIN    = S_FIN,
        CSUM   = S_CSUM
    } state_t;

    // Header is a 2-byte big-endian word count; each word is 4 bytes MSB-first.
    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: 32-bit shift register plus a 2-bit byte
// counter. word_full flags the shift that completes a word, so the full
// word is on 'word' in the following cycle.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_full
);

    logic [31:0] r_word;
    logic [1:0]  r_cnt;

    // Shift bytes in MSB-first; the counter wraps to 0 after each full word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (clr) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (shift_en) begin
            r_word <= {r_word[23:0], din};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    assign word      = r_word;
    assign word_full = shift_en && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a 2-byte word-count header followed by
// big-endian data words over a byte stream, writes them to consecutive word
// addresses from 0, and holds the CPU in reset while loading.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// and the sticky err_csum output.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err_len,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic              err_csum,
`endif
    output logic [2:0]        dbg_state
);

    // Handshake: a byte moves on a rising clk edge where rx_valid && rx_ready;
    // rx_ready depends only on state, never on rx_valid, and the sender keeps
    // rx_data stable while rx_valid is high.

    // Largest legal word count: the full memory, 2^ADDR_W words.
    localparam logic [LEN_W:0] LEN_MAX = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    state_t              r_state, w_next;
    logic [LEN_W-1:0]    r_count;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_err_len;
    logic                w_xfer, w_shift, w_clr, w_full, w_last;
    logic                w_len_zero, w_len_big;
    logic [LEN_W-1:0]    w_len;
    logic [31:0]         w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          r_csum;
    logic                r_err_csum;
`endif

    assign w_xfer     = rx_valid && rx_ready;
    assign w_shift    = w_xfer && (r_state == DATA);
    assign w_clr      = (r_state == IDLE) && start;
    assign w_len      = {r_count[LEN_W-1:8], rx_data};
    assign w_len_zero = (w_len == '0);
    assign w_len_big  = ({1'b0, w_len} > LEN_MAX);
    // Header check guarantees count >= 1 whenever WRITE is reached.
    assign w_last     = (LEN_W'(r_idx) == (r_count - 1'b1));

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (w_clr),
        .shift_en  (w_shift),
        .din       (rx_data),
        .word      (w_word),
        .word_full (w_full)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        imem_we  = 1'b0;
        cpu_hold = 1'b0;
        busy     = (r_state != IDLE);
        done     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = LEN_HI;
            end
            LEN_HI: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
                if (w_xfer) w_next = LEN_LO;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
                if (w_xfer) begin
                    if (w_len_zero)     w_next = FIN;
                    else if (w_len_big) w_next = IDLE;
                    else                w_next = DATA;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
                if (w_full) w_next = WRITE;
            end
            WRITE: begin
                imem_we  = 1'b1;
                cpu_hold = 1'b1;
                if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_next = CSUM;
`else
                    w_next = FIN;
`endif
                end else begin
                    w_next = DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
                if (w_xfer) w_next = FIN;
            end
`endif
            FIN: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Header capture, word index, held write address/data and error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= '0;
            r_idx     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_err_len <= 1'b0;
        end else begin
            if (w_clr) begin
                r_count   <= '0;
                r_idx     <= '0;
                r_err_len <= 1'b0;
            end
            if ((r_state == LEN_HI) && w_xfer) r_count[LEN_W-1:8] <= rx_data;
            if ((r_state == LEN_LO) && w_xfer) begin
                r_count[7:0] <= rx_data;
                if (w_len_big) r_err_len <= 1'b1;
            end
            if (r_state == WRITE) begin
                r_addr  <= r_idx;
                r_wdata <= w_word;
                r_idx   <= r_idx + 1'b1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of data bytes, compared against the trailing checksum byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_csum     <= '0;
            r_err_csum <= 1'b0;
        end else begin
            if (w_clr) begin
                r_csum     <= '0;
                r_err_csum <= 1'b0;
            end
            if (w_shift) r_csum <= r_csum ^ rx_data;
            if ((r_state == CSUM) && w_xfer && (rx_data != r_csum)) r_err_csum <= 1'b1;
        end
    end

    assign err_csum = r_err_csum;
`endif

    // Live index/word during WRITE, last written values otherwise.
    assign imem_addr  = (r_state == WRITE) ? r_idx  : r_addr;
    assign imem_wdata = (r_state == WRITE) ? w_word : r_wdata;
    assign err_len    = r_err_len;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: hand-written timing sequences plus a
// table of header lengths driven with random data bytes; expected writes come
// from a big-endian packing model held in a scoreboard queue.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err_len;
    logic [2:0]        dbg_state;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic              err_csum;
`endif

    imem_loader #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err_len    (err_len),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .err_csum   (err_csum),
`endif
        .dbg_state  (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    logic [ADDR_W+31:0] exp_q[$];

    typedef struct {
        logic [15:0] len;
        bit          gap;
        bit          exp_err;
        bit          exp_done;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset) begin
            if (done) n_done++;
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                             imem_addr, imem_wdata);
                end else begin
                    check("write_addr_data", {imem_addr, imem_wdata}, exp_q.pop_front());
                end
                check("rx_ready_in_write", rx_ready, 1'b0);
            end
        end
    end

    // Driver: present a byte and hold it until the DUT accepts it.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("byte_accept_timeout", rx_ready, 1'b1);
        @(negedge clk);
        rx_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    // Model: four bytes form one big-endian word.
    function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
        int unsigned w;
        w = b0 * 32'd16777216 + b1 * 32'd65536 + b2 * 32'd256 + b3;
        return w;
    endfunction

    task automatic send_word(input int addr, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input bit gap);
        exp_q.push_back({ADDR_W'(addr), pack(b0, b1, b2, b3)});
        send_byte(b0, gap);
        send_byte(b1, gap);
        send_byte(b2, gap);
        send_byte(b3, gap);
    endtask

    // One full load with random data; expected outcome given by the caller.
    task automatic run_load(input logic [15:0] len, input bit gap, input bit exp_err,
                            input bit exp_done);
        n_done = 0;
        pulse_start();
        check("start_cpu_hold", cpu_hold, 1'b1);
        check("start_busy", busy, 1'b1);
        check("start_clears_err_len", err_len, 1'b0);
        send_byte(len[15:8], gap);
        send_byte(len[7:0], gap);
        if (!exp_err) begin
            for (int w = 0; w < int'(len); w++) begin
                send_word(w, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), gap);
            end
        end
        wait_idle();
        check("load_done_count", n_done, exp_done ? 1 : 0);
        check("load_err_len", err_len, exp_err);
        check("load_writes_left", exp_q.size(), 0);
        check("load_cpu_hold_after", cpu_hold, 1'b0);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err_len},
              '0);
        reset = 1'b1;
        @(negedge clk);

        // One word with continuous valid; an extra start mid-load is ignored.
        n_done = 0;
        pulse_start();
        check("t1_cpu_hold_after_start", cpu_hold, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        exp_q.push_back({ADDR_W'(0), 32'hDEADBEEF});
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        pulse_start();
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        check("t1_we_one_cycle_after_byte4", imem_we, 1'b1);
        check("t1_hold_in_write", cpu_hold, 1'b1);
        @(negedge clk);
        check("t1_done", done, 1'b1);
        check("t1_hold_drops_in_fin", cpu_hold, 1'b0);
        check("t1_busy_in_fin", busy, 1'b1);
        @(negedge clk);
        check("t1_idle", {done, busy, imem_we}, 3'b000);
        check("t1_addr_wdata_held", {imem_addr, imem_wdata}, {ADDR_W'(0), 32'hDEADBEEF});
        check("t1_done_count", n_done, 1);
        check("t1_writes_left", exp_q.size(), 0);

        // Zero-length header: FIN directly after the LEN_LO handshake cycle.
        n_done = 0;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check("zero_done", done, 1'b1);
        check("zero_no_we", imem_we, 1'b0);
        @(negedge clk);
        check("zero_idle", {done, busy, err_len}, 3'b000);

        // Table of header lengths with random data.
        vecs[0] = '{16'd1,     1'b0, 1'b0, 1'b1};
        vecs[1] = '{16'd3,     1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'd0,     1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'd257,   1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'd2,     1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'd256,   1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'hFFFF,  1'b1, 1'b1, 1'b0};
        for (int i = 7; i < 10; i++) begin
            vecs[i].len      = (i == 9) ? 16'($urandom_range(250, 300))
                                        : 16'($urandom_range(0, 12));
            vecs[i].gap      = 1'($urandom_range(0, 1));
            vecs[i].exp_err  = (int'(vecs[i].len) > CAP);
            vecs[i].exp_done = !vecs[i].exp_err;
        end
        for (int i = 0; i < 10; i++) begin
            run_load(vecs[i].len, vecs[i].gap, vecs[i].exp_err, vecs[i].exp_done);
        end

        // Reset in the middle of word 1, then a clean reload.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(0, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        reset = 1'b0;
        #1;
        check("midreset_outputs",
              {rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err_len},
              '0);
        check("midreset_word0_written", exp_q.size(), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_done = 0;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_word(0, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        wait_idle();
        check("reload_done_count", n_done, 1);
        check("reload_writes_left", exp_q.size(), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Trailing checksum byte: XOR of 01 02 03 04 is 04.
        for (int k = 0; k < 2; k++) begin
            n_done = 0;
            pulse_start();
            send_byte(8'h00, 1'b0);
            send_byte(8'h01, 1'b0);
            send_word(0, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
            send_byte((k == 0) ? 8'h04 : 8'hFF, 1'b0);
            wait_idle();
            check("csum_err", err_csum, (k == 0) ? 1'b0 : 1'b1);
            check("csum_done_count", n_done, 1);
            check("csum_writes_left", exp_q.size(), 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
